// File: rtl/instr_mem_loader.sv
// Loads a byte stream into instruction memory as big-endian 16-bit words while holding the CPU.
// Three cycles per word (HI, LO, WRITE) at best; byte_valid low simply stalls the HI/LO states.
module instr_mem_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] len,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_t      state, nextState;
  logic [15:0] baseReg, lenReg, wordIdx, addrReg, dataReg;
  logic [7:0]  hiByte;
  logic        errReg;
  logic        lenZero, lenTooBig, lastWord;

  assign lenZero   = (len == 16'd0);
  assign lenTooBig = ({1'b0, len} > MaxWords);
  assign lastWord  = (wordIdx == lenReg - 16'd1);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (lenZero)         nextState = DONE;
          else if (!lenTooBig) nextState = HI;
        end
      end
      HI: begin
        byte_ready = 1'b1;
        if (byte_valid) nextState = LO;
      end
      LO: begin
        byte_ready = 1'b1;
        if (byte_valid) nextState = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        nextState = lastWord ? DONE : HI;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Address/data are loaded on the LO transfer so they are stable for the WRITE cycle
  // and keep showing the last written word afterwards.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      baseReg <= '0;
      lenReg  <= '0;
      wordIdx <= '0;
      addrReg <= '0;
      dataReg <= '0;
      hiByte  <= '0;
      errReg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (lenZero) begin
              errReg <= 1'b0;
            end else if (lenTooBig) begin
              errReg <= 1'b1;
            end else begin
              baseReg <= base_addr;
              lenReg  <= len;
              wordIdx <= '0;
              errReg  <= 1'b0;
            end
          end
        end
        HI: if (byte_valid) hiByte <= byte_in;
        LO: begin
          if (byte_valid) begin
            addrReg <= baseReg + wordIdx;
            dataReg <= {hiByte, byte_in};
          end
        end
        WRITE: wordIdx <= wordIdx + 16'd1;
        default: ;
      endcase
    end
  end

  assign mem_addr = addrReg;
  assign mem_data = dataReg;
  assign cpu_hold = busy;
  assign err      = errReg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized checks of instr_mem_loader against a word-list reference model.
module tb_instr_mem_loader;

  localparam int MAXW = 256;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] len = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_we, cpu_hold, busy, done, err;
  logic [15:0] mem_addr, mem_data;

  instr_mem_loader #(.MAX_WORDS(MAXW)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .start(start), .base_addr(base_addr), .len(len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int donePulses = 0;
  logic [15:0] gotAddr[$], gotData[$], expAddr[$], expData[$];

  // Memory-side observer: every cycle with mem_we high is one write.
  always @(negedge CLK) begin
    if (mem_we) begin
      gotAddr.push_back(mem_addr);
      gotData.push_back(mem_data);
    end
    if (done) donePulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reference model: word i of a load goes to base+i (16-bit wrap) as {byte 2i, byte 2i+1}.
  task automatic modelLoad(input logic [15:0] b, input logic [7:0] bq[$]);
    logic [15:0] a;
    for (int i = 0; i < bq.size() / 2; i++) begin
      a = b + 16'(i);
      expAddr.push_back(a);
      expData.push_back({bq[2*i], bq[2*i+1]});
    end
  endtask

  task automatic checkWrites(input string tag);
    int n;
    check({tag, "_nwrites"}, 32'(gotAddr.size()), 32'(expAddr.size()));
    n = (gotAddr.size() < expAddr.size()) ? gotAddr.size() : expAddr.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 32'(gotAddr[i]), 32'(expAddr[i]));
      check({tag, "_data"}, 32'(gotData[i]), 32'(expData[i]));
    end
    gotAddr.delete(); gotData.delete(); expAddr.delete(); expData.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_rdy"},   32'(byte_ready), 0);
    check({tag, "_we"},    32'(mem_we), 0);
    check({tag, "_addr"},  32'(mem_addr), 0);
    check({tag, "_data"},  32'(mem_data), 0);
    check({tag, "_hold"},  32'(cpu_hold), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
  endtask

  // Full load; rnd randomizes byte_valid, poke throws ignored starts while busy.
  task automatic runLoad(input string tag, input logic [15:0] b, input logic [7:0] bq[$],
                         input bit rnd, input bit poke);
    int n, idx, cyc, budget;
    bit took;
    n = bq.size() / 2;
    modelLoad(b, bq);
    base_addr = b; len = 16'(n); start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_err"},  32'(err), 0);
    idx = 0; cyc = 0; budget = 40 * n + 50;
    while (idx < 2 * n && cyc < budget) begin
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in = bq[idx];
      if (poke) begin
        start     = 1'($urandom_range(0, 1));
        len       = 16'($urandom_range(0, 400));
        base_addr = 16'($urandom);
      end
      took = byte_valid && byte_ready;
      tick;
      cyc++;
      if (took) idx++;
    end
    start = 1'b0; byte_valid = 1'b0;
    check({tag, "_bytes"}, 32'(idx), 32'(2 * n));
    cyc = 0;
    while (!done && cyc < 10) begin
      tick;
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 1);
    tick;
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    checkWrites(tag);
  endtask

  initial begin
    logic [7:0] bq[$];
    int ptr, dp;
    bit took;

    // Reset state
    tick; tick;
    checkResetOutputs("reset");
    Reset_n = 1'b1;
    tick;
    checkResetOutputs("post_reset");

    // Back-to-back two-word load with exact cycle timing
    bq = '{8'h12, 8'h34, 8'h56, 8'h78};
    modelLoad(16'h0010, bq);
    base_addr = 16'h0010; len = 16'd2; start = 1'b1;
    tick;
    start = 1'b0; byte_valid = 1'b1; ptr = 0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("t_busy_c%0d", c), 32'(busy), 32'(c <= 7));
      check($sformatf("t_hold_c%0d", c), 32'(cpu_hold), 32'(c <= 7));
      check($sformatf("t_done_c%0d", c), 32'(done), 32'(c == 7));
      check($sformatf("t_we_c%0d", c), 32'(mem_we), 32'(c == 3 || c == 6));
      check($sformatf("t_rdy_c%0d", c), 32'(byte_ready), 32'(c <= 6 && (c % 3) != 0));
      byte_in = (ptr < 4) ? bq[ptr] : 8'h00;
      took = byte_ready;
      tick;
      if (took) ptr++;
    end
    byte_valid = 1'b0;
    checkWrites("timing");

    // Oversize request is rejected and sticky
    base_addr = 16'h0100; len = 16'(MAXW + 1); start = 1'b1;
    tick;
    start = 1'b0;
    check("rej_err", 32'(err), 1);
    check("rej_busy", 32'(busy), 0);
    check("rej_rdy", 32'(byte_ready), 0);
    tick; tick;
    check("rej_err_hold", 32'(err), 1);
    check("rej_busy_hold", 32'(busy), 0);
    checkWrites("rej");

    // Zero-length load clears err and pulses done at once
    len = 16'd0; start = 1'b1;
    tick;
    start = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_err", 32'(err), 0);
    check("zero_we", 32'(mem_we), 0);
    tick;
    check("zero_done_clr", 32'(done), 0);
    check("zero_idle", 32'(busy), 0);
    checkWrites("zero");

    // Reject again, then a valid load must clear err
    len = 16'(MAXW + 1); start = 1'b1;
    tick;
    start = 1'b0;
    check("rej2_err", 32'(err), 1);
    bq = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    runLoad("clr", 16'($urandom), bq, 1'b0, 1'b0);

    // Address wrap past 0xFFFF
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    runLoad("wrap", 16'hFFFF, bq, 1'b0, 1'b0);

    // Randomized byte_valid with ignored starts while busy
    for (int it = 0; it < 8; it++) begin
      bq.delete();
      for (int j = 0; j < 2 * int'($urandom_range(1, 8)); j++)
        bq.push_back(8'($urandom_range(0, 255)));
      runLoad($sformatf("rand%0d", it), 16'($urandom), bq, 1'b1, 1'b1);
    end

    // Largest accepted length
    bq.delete();
    for (int j = 0; j < 2 * MAXW; j++) bq.push_back(8'($urandom_range(0, 255)));
    runLoad("maxlen", 16'hFF80, bq, 1'b0, 1'b0);

    // Reset after the first word of a three-word load
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    expAddr.push_back(16'h0200);
    expData.push_back(16'h1122);
    base_addr = 16'h0200; len = 16'd3; start = 1'b1;
    tick;
    start = 1'b0; byte_valid = 1'b1; ptr = 0;
    for (int c = 0; c < 3; c++) begin
      byte_in = bq[ptr];
      took = byte_ready;
      tick;
      if (took) ptr++;
    end
    dp = donePulses;
    Reset_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    for (int c = 0; c < 4; c++) begin
      byte_in = bq[2 + (c % 4)];
      tick;
      check("midrst_we_held", 32'(mem_we), 0);
    end
    byte_valid = 1'b0;
    Reset_n = 1'b1;
    tick; tick;
    check("midrst_no_done", 32'(donePulses), 32'(dp));
    check("midrst_idle", 32'(busy), 0);
    checkWrites("midrst");

    // Normal operation after reset
    bq = '{8'h9A, 8'hBC};
    runLoad("after_rst", 16'h0300, bq, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
